// File: rtl/mv_decision.sv
// Motion-vector decision: tracks the lowest SAD per coding block during a search and
// streams the four winners over a valid/ready port. Optional zero-MV bias: MV_ZERO_BIAS_EN.
module mv_decision #(
  parameter int unsigned SAD_W    = 16,
  parameter int unsigned ZMV_COL  = 16,
  parameter int unsigned ZMV_ROW  = 32,
  parameter int unsigned ZMV_BIAS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sad_valid,
  input  logic [SAD_W-1:0] sad_in,
  input  logic [1:0]       cb_id,
  input  logic [4:0]       search_column_count,
  input  logic [6:0]       search_row_count,
  input  logic             search_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_cb,
  output logic [SAD_W-1:0] out_sad,
  output logic [4:0]       out_mv_col,
  output logic [6:0]       out_mv_row,
  output logic             out_last,
  output logic             busy
);

  localparam int unsigned NUM_CB = 4;

`ifdef MV_ZERO_BIAS_EN
  localparam bit BIAS_EN = 1'b1;
`else
  localparam bit BIAS_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, TRACK, OUTPUT} state_t;

  state_t           state;
  logic [SAD_W-1:0] best_sad [NUM_CB];
  logic [4:0]       best_col [NUM_CB];
  logic [6:0]       best_row [NUM_CB];

  logic             is_zmv;
  logic [SAD_W-1:0] cand_sad;
  logic             cand_better;
  logic [1:0]       nxt_cb;

  // Candidate SAD as compared and stored, with the zero-MV bias saturating at zero.
  always_comb begin
    is_zmv   = (search_column_count == 5'(ZMV_COL)) && (search_row_count == 7'(ZMV_ROW));
    cand_sad = sad_in;
    if (BIAS_EN && is_zmv) begin
      cand_sad = (sad_in > SAD_W'(ZMV_BIAS)) ? (sad_in - SAD_W'(ZMV_BIAS)) : '0;
    end
    cand_better = (cand_sad < best_sad[cb_id]);
    nxt_cb      = out_cb + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      out_cb     <= '0;
      out_sad    <= '0;
      out_mv_col <= '0;
      out_mv_row <= '0;
      for (int i = 0; i < NUM_CB; i++) begin
        best_sad[i] <= '1;
        best_col[i] <= '0;
        best_row[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= TRACK;
            busy  <= 1'b1;
            for (int i = 0; i < NUM_CB; i++) begin
              best_sad[i] <= '1;
              best_col[i] <= '0;
              best_row[i] <= '0;
            end
          end
        end
        TRACK: begin
          // A restart wins over any candidate or end-of-search in the same cycle.
          if (start) begin
            for (int i = 0; i < NUM_CB; i++) begin
              best_sad[i] <= '1;
              best_col[i] <= '0;
              best_row[i] <= '0;
            end
          end else begin
            if (sad_valid && cand_better) begin
              best_sad[cb_id] <= cand_sad;
              best_col[cb_id] <= search_column_count;
              best_row[cb_id] <= search_row_count;
            end
            if (search_done) begin
              state <= OUTPUT;
            end
          end
        end
        OUTPUT: begin
          // First OUTPUT cycle presents CB0; afterwards each accepted beat loads the next.
          if (!out_valid) begin
            out_valid  <= 1'b1;
            out_last   <= 1'b0;
            out_cb     <= 2'd0;
            out_sad    <= best_sad[0];
            out_mv_col <= best_col[0];
            out_mv_row <= best_row[0];
          end else if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              out_cb     <= nxt_cb;
              out_sad    <= best_sad[nxt_cb];
              out_mv_col <= best_col[nxt_cb];
              out_mv_row <= best_row[nxt_cb];
              out_last   <= (nxt_cb == 2'd3);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mv_decision.sv
// Self-checking bench for mv_decision: directed table, stall/abort sequences and
// randomized searches against a per-CB minimum model.
module tb_mv_decision;

  localparam int unsigned SAD_W = 16;
  localparam int ONES = 65535;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             sad_valid = 1'b0;
  logic [SAD_W-1:0] sad_in = '0;
  logic [1:0]       cb_id = '0;
  logic [4:0]       search_column_count = '0;
  logic [6:0]       search_row_count = '0;
  logic             search_done = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [1:0]       out_cb;
  logic [SAD_W-1:0] out_sad;
  logic [4:0]       out_mv_col;
  logic [6:0]       out_mv_row;
  logic             out_last;
  logic             busy;

  mv_decision #(.SAD_W(SAD_W), .ZMV_COL(16), .ZMV_ROW(32), .ZMV_BIAS(16)) dut (
    .clk(clk), .rst(rst), .start(start), .sad_valid(sad_valid), .sad_in(sad_in),
    .cb_id(cb_id), .search_column_count(search_column_count),
    .search_row_count(search_row_count), .search_done(search_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_cb(out_cb), .out_sad(out_sad),
    .out_mv_col(out_mv_col), .out_mv_row(out_mv_row), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cb;
    int sad;
    int col;
    int row;
  } cand_t;

  typedef struct {
    int sad;
    int col;
    int row;
    int last;
  } beat_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: best candidate per CB, ties keep the first seen.
  int m_sad [4];
  int m_col [4];
  int m_row [4];
  beat_t exp_beat [4];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) begin
      m_sad[i] = ONES;
      m_col[i] = 0;
      m_row[i] = 0;
    end
  endfunction

  function automatic void model_cand(input cand_t c);
    int s;
    s = c.sad;
`ifdef MV_ZERO_BIAS_EN
    if (c.col == 16 && c.row == 32) s = (c.sad > 16) ? c.sad - 16 : 0;
`endif
    if (s < m_sad[c.cb]) begin
      m_sad[c.cb] = s;
      m_col[c.cb] = c.col;
      m_row[c.cb] = c.row;
    end
  endfunction

  function automatic void model_to_exp();
    for (int i = 0; i < 4; i++) begin
      exp_beat[i].sad  = m_sad[i];
      exp_beat[i].col  = m_col[i];
      exp_beat[i].row  = m_row[i];
      exp_beat[i].last = (i == 3) ? 1 : 0;
    end
  endfunction

  task automatic drive_cand(input cand_t c, input bit with_done);
    sad_valid           = 1'b1;
    cb_id               = 2'(c.cb);
    sad_in              = SAD_W'(c.sad);
    search_column_count = 5'(c.col);
    search_row_count    = 7'(c.row);
    search_done         = with_done;
    step();
    sad_valid   = 1'b0;
    search_done = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_done();
    search_done = 1'b1;
    step();
    search_done = 1'b0;
  endtask

  // Drain the four beats; optionally stall on one CB, randomize ready, inject ignored inputs.
  task automatic collect(input int stall_cb, input bit rand_ready, input bit junk);
    int beat, cycles, stalls;
    int s_cb, s_sad, s_col, s_row, s_last;
    bit just_xfer;
    beat = 0; cycles = 0; stalls = 0; just_xfer = 1'b0;
    s_cb = 0; s_sad = 0; s_col = 0; s_row = 0; s_last = 0;
    while (beat < 4 && cycles < 200) begin
      if (junk) begin
        start       = 1'($urandom_range(0, 1));
        search_done = 1'($urandom_range(0, 1));
        sad_valid   = 1'b1;
        cb_id       = 2'($urandom_range(0, 3));
        sad_in      = '0;
      end
      if (just_xfer) check("b2b_valid", int'(out_valid), 1);
      just_xfer = 1'b0;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && beat == stall_cb && stalls <= 3) begin
        if (stalls == 0) begin
          s_cb = out_cb; s_sad = out_sad; s_col = out_mv_col; s_row = out_mv_row; s_last = out_last;
        end else begin
          check("stall_cb", int'(out_cb), s_cb);
          check("stall_sad", int'(out_sad), s_sad);
          check("stall_col", int'(out_mv_col), s_col);
          check("stall_row", int'(out_mv_row), s_row);
          check("stall_last", int'(out_last), s_last);
        end
        out_ready = (stalls == 3);
        stalls++;
      end
      if (out_valid && out_ready) begin
        check("beat_cb", int'(out_cb), beat);
        check("beat_sad", int'(out_sad), exp_beat[beat].sad);
        check("beat_col", int'(out_mv_col), exp_beat[beat].col);
        check("beat_row", int'(out_mv_row), exp_beat[beat].row);
        check("beat_last", int'(out_last), exp_beat[beat].last);
        check("beat_busy", int'(busy), 1);
        beat++;
        just_xfer = (beat < 4);
      end
      step();
      cycles++;
    end
    start = 1'b0; search_done = 1'b0; sad_valid = 1'b0; out_ready = 1'b0;
    if (beat < 4) begin
      n_tests++;
      n_fail++;
      $display("FAIL collect_timeout: got %0d beats expected 4", beat);
    end
    check("end_valid", int'(out_valid), 0);
    check("end_busy", int'(busy), 0);
  endtask

  cand_t dir_c [6];
  beat_t dir_b [4];

  initial begin
    // Directed search: CB0 tie case, CB1 coincident with done, CB2 empty, CB3 zero-MV.
    dir_c[0] = '{cb: 0, sad: 500, col: 3,  row: 10};
    dir_c[1] = '{cb: 0, sad: 200, col: 7,  row: 20};
    dir_c[2] = '{cb: 0, sad: 200, col: 9,  row: 4};
    dir_c[3] = '{cb: 3, sad: 100, col: 5,  row: 5};
    dir_c[4] = '{cb: 3, sad: 110, col: 16, row: 32};
    dir_c[5] = '{cb: 1, sad: 50,  col: 2,  row: 2};
    dir_b[0] = '{sad: 200,  col: 7, row: 20, last: 0};
    dir_b[1] = '{sad: 50,   col: 2, row: 2,  last: 0};
    dir_b[2] = '{sad: ONES, col: 0, row: 0,  last: 0};
`ifdef MV_ZERO_BIAS_EN
    dir_b[3] = '{sad: 94,   col: 16, row: 32, last: 1};
`else
    dir_b[3] = '{sad: 100,  col: 5,  row: 5,  last: 1};
`endif

    rst = 1'b1;
    step();
    step();
    check("rst_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_last", int'(out_last), 0);
    check("rst_cb", int'(out_cb), 0);
    check("rst_sad", int'(out_sad), 0);
    check("rst_col", int'(out_mv_col), 0);
    check("rst_row", int'(out_mv_row), 0);
    rst = 1'b0;

    // Candidates and done pulses in IDLE are ignored.
    drive_cand(dir_c[5], 1'b1);
    check("idle_busy", int'(busy), 0);
    check("idle_valid", int'(out_valid), 0);

    pulse_start();
    check("track_busy", int'(busy), 1);
    for (int i = 0; i < 6; i++) drive_cand(dir_c[i], i == 5);
    for (int i = 0; i < 4; i++) exp_beat[i] = dir_b[i];
    collect(1, 1'b0, 1'b0);

    // Abort with reset while CB1 beat is pending, then a clean search.
    pulse_start();
    drive_cand('{cb: 0, sad: 30, col: 4, row: 4}, 1'b0);
    drive_cand('{cb: 1, sad: 80, col: 1, row: 1}, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (out_valid && out_cb == 2'd1) break;
      step();
    end
    out_ready = 1'b0;
    check("pre_abort_cb", int'(out_cb), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_valid", int'(out_valid), 0);
    check("abort_busy", int'(busy), 0);
    out_ready = 1'b1;
    step();
    check("abort_quiet", int'(out_valid), 0);
    out_ready = 1'b0;
    pulse_start();
    drive_cand('{cb: 1, sad: 50, col: 2, row: 2}, 1'b1);
    exp_beat[0] = '{sad: ONES, col: 0, row: 0, last: 0};
    exp_beat[1] = '{sad: 50,   col: 2, row: 2, last: 0};
    exp_beat[2] = '{sad: ONES, col: 0, row: 0, last: 0};
    exp_beat[3] = '{sad: ONES, col: 0, row: 0, last: 1};
    collect(-1, 1'b0, 1'b0);

    // Randomized searches against the reference model.
    for (int t = 0; t < 30; t++) begin
      int n;
      cand_t c;
      model_clear();
      pulse_start();
      n = $urandom_range(0, 14);
      for (int k = 0; k < n; k++) begin
        c.cb  = $urandom_range(0, 3);
        c.sad = $urandom_range(0, 400);
        if ($urandom_range(0, 3) == 0) begin
          c.col = 16; c.row = 32;
        end else begin
          c.col = $urandom_range(0, 31); c.row = $urandom_range(0, 127);
        end
        if ($urandom_range(0, 9) == 0) begin
          // Restart with a coincident candidate: everything so far is discarded.
          start = 1'b1;
          drive_cand(c, 1'b0);
          start = 1'b0;
          model_clear();
        end else begin
          model_cand(c);
          drive_cand(c, (k == n - 1) && $urandom_range(0, 1) == 1);
          if ($urandom_range(0, 2) == 0) step();
        end
      end
      if (busy && !out_valid && dut.state != 2'd2) pulse_done();
      model_to_exp();
      collect(-1, 1'b1, t[0]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
